dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory between the CPU load/store path and a DMA/loader requester. Each requester has a valid/ready request channel and a registered one-cycle response. Grants are round-robin, with an optional bounded lock for bursts. The arbiter sits between the datapath's memory address/store-data/write-enable signals and `data_mem`. The CPU stalls its PC while `cpu_req_ready` is low.

---
 rtl/dmem_arb_pkg.sv | 24 ++
 rtl/dmem_arbiter_rr_pick2.sv | 26 ++
 rtl/dmem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (dmem_arbiter) and its
// round-robin picker.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_LOCK_CPU = 2'd1,
      ARB_LOCK_DMA = 2'd2
   } arb_state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DMA = 1'b1;

   localparam int unsigned ARB_STALL_CNT_W = 32;

   function automatic logic [ARB_STALL_CNT_W-1:0] sat_inc(input logic [ARB_STALL_CNT_W-1:0] v);
      if (&v) begin
         sat_inc = v;
      end else begin
         sat_inc = v + {{(ARB_STALL_CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin select; bit 0 is the CPU, bit 1 the DMA.
// A set lock_mask bit removes that requester from contention for the cycle.
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic       valid_cpu,
   input  logic       valid_dma,
   input  logic       last_grant,
   input  logic [1:0] lock_mask,
   output logic [1:0] grant
);

   logic [1:0] elig_s;

   // On a tie the requester that did not own the previous beat wins.
   always_comb begin
      elig_s = {valid_dma, valid_cpu} & ~lock_mask;
      case (elig_s)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last_grant == REQ_DMA) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares data_mem between the CPU load/store path and a DMA requester.
// Define DMEM_ARB_LOCK_EN to build the bounded burst lock (up to MAX_LOCK beats).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned MAX_LOCK = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       cpu_req_valid,
   output logic                       cpu_req_ready,
   input  logic [DATA_W-1:0]          cpu_addr,
   input  logic [DATA_W-1:0]          cpu_wdata,
   input  logic                       cpu_word_we,
   input  logic                       cpu_byte_we,
   input  logic                       cpu_lock,
   output logic                       cpu_rsp_valid,
   output logic [DATA_W-1:0]          cpu_rsp_data,
   input  logic                       dma_req_valid,
   output logic                       dma_req_ready,
   input  logic [DATA_W-1:0]          dma_addr,
   input  logic [DATA_W-1:0]          dma_wdata,
   input  logic                       dma_word_we,
   input  logic                       dma_byte_we,
   input  logic                       dma_lock,
   output logic                       dma_rsp_valid,
   output logic [DATA_W-1:0]          dma_rsp_data,
   output logic [DATA_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   output logic                       mem_word_we,
   output logic                       mem_byte_we,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic [ARB_STALL_CNT_W-1:0] cpu_stall_cnt
);

   logic [1:0]                 grant_s;
   logic [1:0]                 lock_mask_s;
   logic                       cpu_acc_s;
   logic                       dma_acc_s;
   logic                       last_grant_q, last_grant_d;
   logic                       cpu_rsp_valid_q, cpu_rsp_valid_d;
   logic                       dma_rsp_valid_q, dma_rsp_valid_d;
   logic [DATA_W-1:0]          cpu_rsp_data_q, cpu_rsp_data_d;
   logic [DATA_W-1:0]          dma_rsp_data_q, dma_rsp_data_d;
   logic [ARB_STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   rr_pick2 u_pick (
      .valid_cpu  (cpu_req_valid),
      .valid_dma  (dma_req_valid),
      .last_grant (last_grant_q),
      .lock_mask  (lock_mask_s),
      .grant      (grant_s)
   );

   // Acceptance and memory drive; reset blocks every beat, so nothing reaches data_mem.
   always_comb begin
      cpu_acc_s = grant_s[0] & ~reset;
      dma_acc_s = grant_s[1] & ~reset;
      if (cpu_acc_s) begin
         mem_addr    = {cpu_addr[DATA_W-1:3], 3'b000};
         mem_wdata   = cpu_wdata;
         mem_word_we = cpu_word_we;
         mem_byte_we = cpu_byte_we;
      end else if (dma_acc_s) begin
         mem_addr    = {dma_addr[DATA_W-1:3], 3'b000};
         mem_wdata   = dma_wdata;
         mem_word_we = dma_word_we;
         mem_byte_we = dma_byte_we;
      end else begin
         mem_addr    = {DATA_W{1'b0}};
         mem_wdata   = {DATA_W{1'b0}};
         mem_word_we = 1'b0;
         mem_byte_we = 1'b0;
      end
   end

   assign cpu_req_ready = cpu_acc_s;
   assign dma_req_ready = dma_acc_s;

   // Response capture (pre-write read data), round-robin history and stall counting.
   always_comb begin
      if (cpu_acc_s) begin
         last_grant_d = REQ_CPU;
      end else if (dma_acc_s) begin
         last_grant_d = REQ_DMA;
      end else begin
         last_grant_d = last_grant_q;
      end
      cpu_rsp_valid_d = cpu_acc_s;
      dma_rsp_valid_d = dma_acc_s;
      cpu_rsp_data_d  = cpu_acc_s ? mem_rdata : cpu_rsp_data_q;
      dma_rsp_data_d  = dma_acc_s ? mem_rdata : dma_rsp_data_q;
      if (cpu_req_valid & ~cpu_req_ready) begin
         stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_grant_q    <= REQ_DMA;
         cpu_rsp_valid_q <= 1'b0;
         dma_rsp_valid_q <= 1'b0;
         cpu_rsp_data_q  <= {DATA_W{1'b0}};
         dma_rsp_data_q  <= {DATA_W{1'b0}};
         stall_cnt_q     <= {ARB_STALL_CNT_W{1'b0}};
      end else begin
         last_grant_q    <= last_grant_d;
         cpu_rsp_valid_q <= cpu_rsp_valid_d;
         dma_rsp_valid_q <= dma_rsp_valid_d;
         cpu_rsp_data_q  <= cpu_rsp_data_d;
         dma_rsp_data_q  <= dma_rsp_data_d;
         stall_cnt_q     <= stall_cnt_d;
      end
   end

   assign cpu_rsp_valid = cpu_rsp_valid_q;
   assign dma_rsp_valid = dma_rsp_valid_q;
   assign cpu_rsp_data  = cpu_rsp_data_q;
   assign dma_rsp_data  = dma_rsp_data_q;
   assign cpu_stall_cnt = stall_cnt_q;

`ifdef DMEM_ARB_LOCK_EN
   arb_state_t state_q, state_d;
   arb_state_t owner_state_s;
   logic [7:0] lock_cnt_q, lock_cnt_d;
   logic       beat_lock_s;
   logic [8:0] run_s;
   logic       unused_s;

   // Lock state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ARB_IDLE;
         lock_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // run_s counts consecutive locked beats including this one; reaching MAX_LOCK releases.
   always_comb begin
      beat_lock_s   = dma_acc_s ? dma_lock : cpu_lock;
      owner_state_s = dma_acc_s ? ARB_LOCK_DMA : ARB_LOCK_CPU;
      run_s         = (state_q == owner_state_s) ? ({1'b0, lock_cnt_q} + 9'd1) : 9'd1;
      if ((cpu_acc_s | dma_acc_s) & beat_lock_s & (run_s < 9'(MAX_LOCK))) begin
         state_d    = owner_state_s;
         lock_cnt_d = run_s[7:0];
      end else begin
         state_d    = ARB_IDLE;
         lock_cnt_d = 8'd0;
      end
   end

   // The lock only shuts out the other side while the owner is still requesting.
   always_comb begin
      case (state_q)
         ARB_LOCK_CPU: lock_mask_s = cpu_req_valid ? 2'b10 : 2'b00;
         ARB_LOCK_DMA: lock_mask_s = dma_req_valid ? 2'b01 : 2'b00;
         default:      lock_mask_s = 2'b00;
      endcase
   end

   assign unused_s = &{1'b0, cpu_addr[2:0], dma_addr[2:0]};
`else
   logic unused_s;

   assign lock_mask_s = 2'b00;
   assign unused_s    = &{1'b0, cpu_lock, dma_lock, cpu_addr[2:0], dma_addr[2:0]};
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, lock/reset/saturation sequences and
// random traffic checked against a transaction-level model with its own memory copy.
`timescale 1ns/1ps
module tb_dmem_arbiter;

   localparam int MAXL = 3;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic        word_we;
      logic        byte_we;
      logic        lock;
   } req_t;

   typedef struct packed {
      req_t        c;
      req_t        d;
      logic        crdy;
      logic        drdy;
      logic [63:0] maddr;
      logic        mwe;
      logic        cv;
      logic        dv;
      logic [63:0] cdata;
      logic [63:0] ddata;
      logic [31:0] stall;
   } vec_t;

   logic        clock, reset;
   logic        cpu_req_valid, cpu_req_ready, cpu_word_we, cpu_byte_we, cpu_lock, cpu_rsp_valid;
   logic        dma_req_valid, dma_req_ready, dma_word_we, dma_byte_we, dma_lock, dma_rsp_valid;
   logic [63:0] cpu_addr, cpu_wdata, cpu_rsp_data, dma_addr, dma_wdata, dma_rsp_data;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_word_we, mem_byte_we;
   logic [31:0] cpu_stall_cnt;

   logic [63:0] dmem [64];
   logic [63:0] shadow [64];

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int          m_last;
   int          m_owner;
   int          m_run;
   logic        m_cv, m_dv;
   logic [63:0] m_cd, m_dd;
   logic [31:0] m_stall;

   logic        obs_crdy, obs_drdy, obs_mwe, obs_mbe;
   logic [63:0] obs_maddr, obs_mwd;

   dmem_arbiter #(.DATA_W(64), .MAX_LOCK(MAXL)) dut (
      .clock(clock), .reset(reset),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_word_we(cpu_word_we),
      .cpu_byte_we(cpu_byte_we), .cpu_lock(cpu_lock),
      .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
      .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_word_we(dma_word_we),
      .dma_byte_we(dma_byte_we), .dma_lock(dma_lock),
      .dma_rsp_valid(dma_rsp_valid), .dma_rsp_data(dma_rsp_data),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_word_we(mem_word_we),
      .mem_byte_we(mem_byte_we), .mem_rdata(mem_rdata), .cpu_stall_cnt(cpu_stall_cnt)
   );

   assign mem_rdata = dmem[mem_addr[8:3]];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   function automatic req_t mk(input logic v, input logic [63:0] a, input logic [63:0] wd,
                               input logic wwe, input logic bwe, input logic lk);
      req_t r;
      r.valid = v; r.addr = a; r.wdata = wd; r.word_we = wwe; r.byte_we = bwe; r.lock = lk;
      return r;
   endfunction

   function automatic vec_t mkv(input req_t c, input req_t d, input logic crdy, input logic drdy,
                                input logic [63:0] maddr, input logic mwe, input logic cv,
                                input logic dv, input logic [63:0] cdata, input logic [63:0] ddata,
                                input logic [31:0] stall);
      vec_t v;
      v.c = c; v.d = d; v.crdy = crdy; v.drdy = drdy; v.maddr = maddr; v.mwe = mwe;
      v.cv = cv; v.dv = dv; v.cdata = cdata; v.ddata = ddata; v.stall = stall;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input req_t c, input req_t d);
      cpu_req_valid = c.valid; cpu_addr = c.addr; cpu_wdata = c.wdata;
      cpu_word_we = c.word_we; cpu_byte_we = c.byte_we; cpu_lock = c.lock;
      dma_req_valid = d.valid; dma_addr = d.addr; dma_wdata = d.wdata;
      dma_word_we = d.word_we; dma_byte_we = d.byte_we; dma_lock = d.lock;
   endtask

   task automatic model_reset();
      m_last = 1; m_owner = -1; m_run = 0;
      m_cv = 1'b0; m_dv = 1'b0; m_cd = 64'd0; m_dd = 64'd0; m_stall = 32'd0;
   endtask

   // One clock of traffic: winner from the arbitration rules, then the beat's effects.
   task automatic apply(input req_t c, input req_t d, output int w);
      logic [1:0]  v;
      logic [63:0] ea, ewd;
      logic        ewe, ebe, lk;
      int          idx, run;
      @(negedge clock);
      drive(c, d);
      #2;
      v = {d.valid, c.valid};
      if (m_owner == 0 && c.valid) v = 2'b01;
      else if (m_owner == 1 && d.valid) v = 2'b10;
      if (v == 2'b11) w = (m_last == 1) ? 0 : 1;
      else if (v == 2'b01) w = 0;
      else if (v == 2'b10) w = 1;
      else w = -1;
      ea = 64'd0; ewd = 64'd0; ewe = 1'b0; ebe = 1'b0; lk = 1'b0;
      if (w == 0) begin
         ea = c.addr & ~64'h7; ewd = c.wdata; ewe = c.word_we; ebe = c.byte_we; lk = c.lock;
      end else if (w == 1) begin
         ea = d.addr & ~64'h7; ewd = d.wdata; ewe = d.word_we; ebe = d.byte_we; lk = d.lock;
      end
      obs_crdy = cpu_req_ready; obs_drdy = dma_req_ready; obs_maddr = mem_addr;
      obs_mwd = mem_wdata; obs_mwe = mem_word_we; obs_mbe = mem_byte_we;
      chk("cpu_req_ready", obs_crdy, w == 0);
      chk("dma_req_ready", obs_drdy, w == 1);
      chk("mem_addr", obs_maddr, ea);
      chk("mem_wdata", obs_mwd, ewd);
      chk("mem_word_we", obs_mwe, ewe);
      chk("mem_byte_we", obs_mbe, ebe);
      @(posedge clock);
      #1;
      if (obs_mwe) dmem[obs_maddr[8:3]] = obs_mwd;
      else if (obs_mbe) dmem[obs_maddr[8:3]][7:0] = obs_mwd[7:0];
      idx = int'(ea[8:3]);
      m_cv = (w == 0);
      m_dv = (w == 1);
      if (w == 0) m_cd = shadow[idx];
      if (w == 1) m_dd = shadow[idx];
      if (w >= 0) begin
         if (ewe) shadow[idx] = ewd;
         else if (ebe) shadow[idx][7:0] = ewd[7:0];
         m_last = w;
      end
      if (c.valid && w != 0 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`ifdef DMEM_ARB_LOCK_EN
      if (w >= 0 && lk) begin
         run = (m_owner == w) ? m_run + 1 : 1;
         if (run >= MAXL) begin m_owner = -1; m_run = 0; end
         else begin m_owner = w; m_run = run; end
      end else begin
         m_owner = -1; m_run = 0;
      end
`else
      run = 0;
      m_run = run + (lk ? 0 : 0);
`endif
      chk("cpu_rsp_valid", cpu_rsp_valid, m_cv);
      chk("dma_rsp_valid", dma_rsp_valid, m_dv);
      chk("cpu_rsp_data", cpu_rsp_data, m_cd);
      chk("dma_rsp_data", dma_rsp_data, m_dd);
      chk("cpu_stall_cnt", cpu_stall_cnt, m_stall);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_cpu_ready"}, cpu_req_ready, 1'b0);
      chk({tag, "_dma_ready"}, dma_req_ready, 1'b0);
      chk({tag, "_mem_word_we"}, mem_word_we, 1'b0);
      chk({tag, "_mem_byte_we"}, mem_byte_we, 1'b0);
      chk({tag, "_cpu_rsp_valid"}, cpu_rsp_valid, 1'b0);
      chk({tag, "_dma_rsp_valid"}, dma_rsp_valid, 1'b0);
      chk({tag, "_cpu_rsp_data"}, cpu_rsp_data, 64'd0);
      chk({tag, "_dma_rsp_data"}, dma_rsp_data, 64'd0);
      chk({tag, "_stall"}, cpu_stall_cnt, 32'd0);
   endtask

   initial begin
      vec_t tbl [8];
      req_t idle, c, d;
      int   w, dbeats;
      int   seq [$];
      int   exp_seq [6];

      idle = mk(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
      tbl[0] = mkv(mk(1'b1, 64'h10, 64'd0, 1'b0, 1'b0, 1'b0), idle, 1'b1, 1'b0, 64'h10, 1'b0,
                   1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'd0, 32'd0);
      tbl[1] = mkv(idle, mk(1'b1, 64'h28, 64'd0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1, 64'h28, 1'b0,
                   1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'hC0DE_0000_0000_0005, 32'd0);
      c = mk(1'b1, 64'h20, 64'h1111, 1'b1, 1'b0, 1'b0);
      d = mk(1'b1, 64'h28, 64'h2222, 1'b1, 1'b0, 1'b0);
      tbl[2] = mkv(c, d, 1'b1, 1'b0, 64'h20, 1'b1, 1'b1, 1'b0,
                   64'hC0DE_0000_0000_0004, 64'hC0DE_0000_0000_0005, 32'd0);
      tbl[3] = mkv(c, d, 1'b0, 1'b1, 64'h28, 1'b1, 1'b0, 1'b1,
                   64'hC0DE_0000_0000_0004, 64'hC0DE_0000_0000_0005, 32'd1);
      tbl[4] = mkv(c, d, 1'b1, 1'b0, 64'h20, 1'b1, 1'b1, 1'b0,
                   64'h1111, 64'hC0DE_0000_0000_0005, 32'd1);
      tbl[5] = mkv(c, d, 1'b0, 1'b1, 64'h28, 1'b1, 1'b0, 1'b1, 64'h1111, 64'h2222, 32'd2);
      tbl[6] = mkv(mk(1'b1, 64'h33, 64'h1234, 1'b1, 1'b0, 1'b0), idle, 1'b1, 1'b0, 64'h30, 1'b1,
                   1'b1, 1'b0, 64'hC0DE_0000_0000_0006, 64'h2222, 32'd2);
      tbl[7] = mkv(mk(1'b1, 64'h30, 64'd0, 1'b0, 1'b0, 1'b0), idle, 1'b1, 1'b0, 64'h30, 1'b0,
                   1'b1, 1'b0, 64'h1234, 64'h2222, 32'd2);
      exp_seq = '{1, 1, 1, 0, 1, 1};

      for (int i = 0; i < 64; i++) begin
         dmem[i]   = 64'hC0DE_0000_0000_0000 | 64'(i);
         shadow[i] = dmem[i];
      end
      dmem[2]   = 64'hDEAD_BEEF_0000_0001;
      shadow[2] = 64'hDEAD_BEEF_0000_0001;

      // Reset state, with both requesters pushing stores
      reset = 1'b1;
      drive(c, d);
      #12;
      reset_checks("reset");
      @(negedge clock);
      drive(idle, idle);
      reset = 1'b0;
      model_reset();

      for (int i = 0; i < 8; i++) begin
         apply(tbl[i].c, tbl[i].d, w);
         chk($sformatf("tbl%0d_crdy", i), obs_crdy, tbl[i].crdy);
         chk($sformatf("tbl%0d_drdy", i), obs_drdy, tbl[i].drdy);
         chk($sformatf("tbl%0d_maddr", i), obs_maddr, tbl[i].maddr);
         chk($sformatf("tbl%0d_mwe", i), obs_mwe, tbl[i].mwe);
         chk($sformatf("tbl%0d_cv", i), cpu_rsp_valid, tbl[i].cv);
         chk($sformatf("tbl%0d_dv", i), dma_rsp_valid, tbl[i].dv);
         chk($sformatf("tbl%0d_cdata", i), cpu_rsp_data, tbl[i].cdata);
         chk($sformatf("tbl%0d_ddata", i), dma_rsp_data, tbl[i].ddata);
         chk($sformatf("tbl%0d_stall", i), cpu_stall_cnt, tbl[i].stall);
      end

      // DMA locked burst of 5 while the CPU keeps requesting (last owner is the CPU)
      dbeats = 0;
      for (int k = 0; k < 12 && dbeats < 5; k++) begin
         apply(mk(1'b1, 64'h40, 64'd0, 1'b0, 1'b0, 1'b0),
               mk(1'b1, 64'h48 + 64'(8 * dbeats), 64'hB000 + 64'(dbeats), 1'b1, 1'b0,
                  (dbeats < 4) ? 1'b1 : 1'b0), w);
         seq.push_back(w);
         if (w == 1) dbeats++;
      end
      chk("burst_dma_beats", dbeats, 5);
`ifdef DMEM_ARB_LOCK_EN
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("burst_grant%0d", k), (k < seq.size()) ? seq[k] : -1, exp_seq[k]);
      end
`endif

      // Asynchronous reset in the middle of a DMA locked burst
      apply(idle, mk(1'b1, 64'h80, 64'hAAAA, 1'b1, 1'b0, 1'b1), w);
      apply(mk(1'b1, 64'h40, 64'd0, 1'b0, 1'b0, 1'b0),
            mk(1'b1, 64'h88, 64'hBBBB, 1'b1, 1'b0, 1'b1), w);
      #2;
      reset = 1'b1;
      #1;
      reset_checks("midreset");
      model_reset();
      @(negedge clock);
      drive(idle, idle);
      reset = 1'b0;
      apply(mk(1'b1, 64'h40, 64'd0, 1'b0, 1'b0, 1'b0),
            mk(1'b1, 64'h88, 64'd0, 1'b0, 1'b0, 1'b0), w);
      chk("first_tie_after_reset_cpu", obs_crdy, 1'b1);

      // Stall counter saturation, counter preset close to its maximum
      force dut.stall_cnt_q = 32'hFFFF_FFFC;
      #1;
      release dut.stall_cnt_q;
      m_stall = 32'hFFFF_FFFC;
      for (int k = 0; k < 10; k++) begin
         apply(mk(1'b1, 64'h50, 64'd0, 1'b0, 1'b0, 1'b0),
               mk(1'b1, 64'h58, 64'd0, 1'b0, 1'b0, 1'b0), w);
      end
      chk("stall_saturated", cpu_stall_cnt, 32'hFFFF_FFFF);

      // Random traffic
      for (int k = 0; k < 300; k++) begin
         c = mk($urandom_range(0, 3) != 0, 64'($urandom_range(0, 511)), {$urandom, $urandom},
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         d = mk($urandom_range(0, 3) != 0, 64'($urandom_range(0, 511)), {$urandom, $urandom},
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         apply(c, d, w);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
